// File: rtl/double_mul.sv
// rtl/double_mul.sv - five-stage pipelined IEEE-754 binary64 multiplier, round-to-nearest-even
`timescale 1ns/1ps
module double_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] z
);

  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  function automatic logic [5:0] lzc53(input logic [52:0] v);
    logic [5:0] n;
    logic       done;
    n    = 6'd0;
    done = 1'b0;
    for (int i = 52; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) done = 1'b1;
        else      n    = n + 6'd1;
      end
    end
    return n;
  endfunction

  // stage registers
  logic               s1_sign_q, s1_sign_d, s1_spec_q, s1_spec_d;
  logic        [63:0] s1_sval_q, s1_sval_d;
  logic        [52:0] s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
  logic signed [12:0] s1_e_q, s1_e_d;

  logic               s2_sign_q, s2_spec_q;
  logic        [63:0] s2_sval_q;
  logic        [79:0] s2_pp_lo_q, s2_pp_lo_d;
  logic        [78:0] s2_pp_hi_q, s2_pp_hi_d;
  logic signed [12:0] s2_e_q;

  logic               s3_sign_q, s3_spec_q;
  logic        [63:0] s3_sval_q;
  logic       [105:0] s3_m_q, s3_m_d;
  logic signed [12:0] s3_e_q, s3_e_d;

  logic               s4_sign_q, s4_spec_q;
  logic        [63:0] s4_sval_q;
  logic        [52:0] s4_mant_q, s4_mant_d;
  logic               s4_g_q, s4_g_d, s4_st_q, s4_st_d;
  logic signed [12:0] s4_e_q, s4_e_d;

  logic        [63:0] z_q, z_d;

  // stage 1: classify, resolve specials, normalise subnormal significands
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [52:0] a_sig, b_sig;
  logic [5:0]  a_lz, b_lz;
  logic [10:0] a_ex, b_ex;

  always_comb begin
    a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
    b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
    a_zero = (a[62:0] == 63'd0);
    b_zero = (b[62:0] == 63'd0);
    a_sig  = {a[62:52] != 11'd0, a[51:0]};
    b_sig  = {b[62:52] != 11'd0, b[51:0]};
    a_lz   = lzc53(a_sig);
    b_lz   = lzc53(b_sig);
    a_ex   = (a[62:52] == 11'd0) ? 11'd1 : a[62:52];
    b_ex   = (b[62:52] == 11'd0) ? 11'd1 : b[62:52];

    s1_sign_d = a[63] ^ b[63];
    s1_ma_d   = a_sig << a_lz;
    s1_mb_d   = b_sig << b_lz;
    s1_e_d    = $signed({2'b00, a_ex}) + $signed({2'b00, b_ex})
              - $signed({7'd0, a_lz}) - $signed({7'd0, b_lz}) - 13'sd1023;

    s1_spec_d = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      s1_sval_d = QNAN;
    else if (a_inf || b_inf)
      s1_sval_d = {s1_sign_d, 11'h7FF, 52'd0};
    else
      s1_sval_d = {s1_sign_d, 63'd0};
  end

  // stage 2: split the 53x53 product into two partial products
  always_comb begin
    s2_pp_lo_d = {27'd0, s1_ma_q} * {53'd0, s1_mb_q[26:0]};
    s2_pp_hi_d = {26'd0, s1_ma_q} * {53'd0, s1_mb_q[52:27]};
  end

  // stage 3: combine partials, place the leading one at bit 105
  logic [105:0] prod;
  always_comb begin
    prod = {26'd0, s2_pp_lo_q} + {s2_pp_hi_q, 27'd0};
    if (prod[105]) begin
      s3_m_d = prod;
      s3_e_d = s2_e_q + 13'sd1;
    end else begin
      s3_m_d = prod << 1;
      s3_e_d = s2_e_q;
    end
  end

  // stage 4: denormalising right shift; shifted-out bits fold into sticky
  logic signed [12:0] den_sh;
  logic [6:0]         sh;
  logic [105:0]       m_sh;
  logic               lost;
  always_comb begin
    den_sh = 13'sd1 - s3_e_q;
    if (s3_e_q < 13'sd1) begin
      sh     = (den_sh > 13'sd127) ? 7'd127 : den_sh[6:0];
      s4_e_d = 13'sd1;
    end else begin
      sh     = 7'd0;
      s4_e_d = s3_e_q;
    end
    m_sh      = s3_m_q >> sh;
    lost      = |(s3_m_q & ~({106{1'b1}} << sh));
    s4_mant_d = m_sh[105:53];
    s4_g_d    = m_sh[52];
    s4_st_d   = (|m_sh[51:0]) | lost;
  end

  // stage 5: round to nearest even and pack; a subnormal may carry into the hidden bit
  logic               rnd_inc;
  logic [53:0]        mant_r;
  logic signed [12:0] e_fin;
  always_comb begin
    rnd_inc = s4_g_q & (s4_st_q | s4_mant_q[0]);
    mant_r  = {1'b0, s4_mant_q} + {53'd0, rnd_inc};
    e_fin   = s4_e_q + $signed({12'd0, mant_r[53]});
    if (s4_spec_q)
      z_d = s4_sval_q;
    else if (e_fin >= 13'sd2047)
      z_d = {s4_sign_q, 11'h7FF, 52'd0};
    else if (mant_r[53])
      z_d = {s4_sign_q, e_fin[10:0], 52'd0};
    else
      z_d = {s4_sign_q, mant_r[52] ? s4_e_q[10:0] : 11'd0, mant_r[51:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign_q <= 1'b0; s1_spec_q <= 1'b0; s1_sval_q <= '0;
      s1_ma_q   <= '0;   s1_mb_q   <= '0;   s1_e_q    <= '0;
      s2_sign_q <= 1'b0; s2_spec_q <= 1'b0; s2_sval_q <= '0;
      s2_pp_lo_q <= '0;  s2_pp_hi_q <= '0;  s2_e_q    <= '0;
      s3_sign_q <= 1'b0; s3_spec_q <= 1'b0; s3_sval_q <= '0;
      s3_m_q    <= '0;   s3_e_q    <= '0;
      s4_sign_q <= 1'b0; s4_spec_q <= 1'b0; s4_sval_q <= '0;
      s4_mant_q <= '0;   s4_g_q    <= 1'b0; s4_st_q   <= 1'b0;
      s4_e_q    <= '0;
      z_q       <= '0;
    end else begin
      s1_sign_q <= s1_sign_d; s1_spec_q <= s1_spec_d; s1_sval_q <= s1_sval_d;
      s1_ma_q   <= s1_ma_d;   s1_mb_q   <= s1_mb_d;   s1_e_q    <= s1_e_d;
      s2_sign_q <= s1_sign_q; s2_spec_q <= s1_spec_q; s2_sval_q <= s1_sval_q;
      s2_pp_lo_q <= s2_pp_lo_d; s2_pp_hi_q <= s2_pp_hi_d; s2_e_q <= s1_e_q;
      s3_sign_q <= s2_sign_q; s3_spec_q <= s2_spec_q; s3_sval_q <= s2_sval_q;
      s3_m_q    <= s3_m_d;    s3_e_q    <= s3_e_d;
      s4_sign_q <= s3_sign_q; s4_spec_q <= s3_spec_q; s4_sval_q <= s3_sval_q;
      s4_mant_q <= s4_mant_d; s4_g_q    <= s4_g_d;    s4_st_q   <= s4_st_d;
      s4_e_q    <= s4_e_d;
      z_q       <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_double_mul.sv
// tb/tb_double_mul.sv - randomized and directed bench for double_mul against a real-arithmetic model
`timescale 1ns/1ps
module tb_double_mul;

  logic        clk;
  logic        rst;
  logic [63:0] a, b, z;

  double_mul dut (.clk(clk), .rst(rst), .a(a), .b(b), .z(z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vectors     = 0;
  int          n_miscompares = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vectors++;
    if (got !== want) begin
      n_miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // the host multiply is binary64 round-to-nearest-even; only NaN encoding differs
  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
    real         r;
    logic [63:0] p;
    r = $bitstoreal(x) * $bitstoreal(y);
    p = $realtobits(r);
    if (p[62:52] == 11'h7FF && p[51:0] != 52'd0) p = 64'h7FF8000000000000;
    return p;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: v[62:52] = 11'd0;
      1: v[62:0]  = 63'd0;
      2: begin
        v[62:52] = 11'h7FF;
        if ($urandom_range(0, 1) == 0) v[51:0] = 52'd0;
      end
      3: v[62:52] = 11'(11'h3FE + $urandom_range(0, 2));
      4: v[62:52] = 11'($urandom_range(1, 40));
      5: v[62:52] = 11'($urandom_range(2000, 2046));
      6: v[62:52] = 11'($urandom_range(470, 560));
      7: v[51:0]  = 52'hFFFFFFFFFFFFF;
      default: ;
    endcase
    return v;
  endfunction

  // expected result leaves the pipeline 5 negedges after the operands were driven
  task automatic apply(input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] want, input string tag);
    logic [63:0] e;
    string       t;
    if (exp_q.size() == 5) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, z, e);
    end else begin
      check("fill_zero", z, 64'd0);
    end
    a = x;
    b = y;
    exp_q.push_back(want);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  logic [63:0] d_a[12] = '{64'h4000000000000000, 64'h3FF0000000000000, 64'h8000000000000000,
                           64'h7FF0000000000000, 64'h7FF0000000000000, 64'hFFF0000000000123,
                           64'h7FEFFFFFFFFFFFFF, 64'h0000000000000001, 64'h0000000000000001,
                           64'h3FF0000000000001, 64'h0000000000000000, 64'h000FFFFFFFFFFFFF};
  logic [63:0] d_b[12] = '{64'h4008000000000000, 64'hBFF8000000000000, 64'h4014000000000000,
                           64'h0000000000000000, 64'hC000000000000000, 64'h3FF0000000000000,
                           64'h4000000000000000, 64'h4000000000000000, 64'h3FE0000000000000,
                           64'h3FF0000000000001, 64'hFFF0000000000000, 64'h3FF0000000000001};
  logic [63:0] d_z[12] = '{64'h4018000000000000, 64'hBFF8000000000000, 64'h8000000000000000,
                           64'h7FF8000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000,
                           64'h7FF0000000000000, 64'h0000000000000002, 64'h0000000000000000,
                           64'h3FF0000000000002, 64'h7FF8000000000000, 64'h0010000000000000};
  string d_tag[12] = '{"two_x_three", "sign_neg", "neg_zero", "inf_x_zero", "inf_x_neg",
                       "nan_in", "overflow", "subn_x2", "subn_tie_even", "round_lsb",
                       "zero_x_inf", "subn_to_min_normal"};

  initial begin
    logic [63:0] x, y;
    rst = 1'b1;
    a   = 64'd0;
    b   = 64'd0;
    repeat (2) @(negedge clk);
    check("reset_z", z, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) apply(d_a[i], d_b[i], d_z[i], d_tag[i]);

    for (int i = 0; i < 3000; i++) begin
      x = rand_op();
      y = rand_op();
      apply(x, y, ref_mul(x, y), "random");
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1 check("rst_async_z", z, 64'd0);
        repeat (2) @(negedge clk);
        check("rst_hold_z", z, 64'd0);
        exp_q.delete();
        tag_q.delete();
        rst = 1'b0;
      end
    end

    for (int i = 0; i < 5; i++) apply(64'd0, 64'd0, 64'd0, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
